// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
package conv_pkg;

  localparam int NUM_TAPS = 9;
  localparam int TAP_W    = 4;
  localparam int KSIZE    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WAIT_MAC,
    ST_WR_REQ,
    ST_ADVANCE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Incremental tap-address generator for a 3x3 valid-mode window walk.
// The walk is row-major and uses only adders, so no multiplier is needed.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step_tap,
  input  logic              step_out,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              end_of_img
);

  logic [ADDR_W-1:0] win_base;
  logic [ADDR_W-1:0] row_skip;
  logic [ADDR_W-1:0] next_win;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [1:0]        kx;
  logic              end_of_row;

  // Skip from the window's right column to the next window row.
  // At the last column of an output row, advancing by KSIZE lands on the next row's first window.
  assign row_skip   = ADDR_W'(img_w) - ADDR_W'(KSIZE - 1);
  assign end_of_row = (col == img_w - DIM_W'(KSIZE));
  assign end_of_img = end_of_row && (row == img_h - DIM_W'(KSIZE));
  assign next_win   = win_base + (end_of_row ? ADDR_W'(KSIZE) : ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_base <= '0;
      tap_addr <= '0;
      kx       <= '0;
      col      <= '0;
      row      <= '0;
    end else if (load) begin
      win_base <= src_base;
      tap_addr <= src_base;
      kx       <= '0;
      col      <= '0;
      row      <= '0;
    end else if (step_out) begin
      win_base <= next_win;
      tap_addr <= next_win;
      kx       <= '0;
      if (end_of_row) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else if (step_tap) begin
      if (kx == 2'(KSIZE - 1)) begin
        kx       <= '0;
        tap_addr <= tap_addr + row_skip;
      end else begin
        kx       <= kx + 1'b1;
        tap_addr <= tap_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences 3x3 valid-mode convolution: fetches window pixels from the data RAM,
// streams them to the MAC with tap indices, and writes each MAC result back.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [TAP_W-1:0]  k_idx,
  output logic              pix_first,
  output logic              pix_last,
  input  logic              mac_done,
  input  logic [DATA_W-1:0] mac_result
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  state_t            state;
  logic [DIM_W-1:0]  img_w_q;
  logic [DIM_W-1:0]  img_h_q;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] tap_addr;
  logic [TAP_W-1:0]  tap;
  logic              last_out;
  logic              end_of_img;
  logic              load;
  logic              step_tap;
  logic              step_out;

  // The generator is stepped on grant edges so the next address is ready one cycle later.
  assign load     = (state == ST_IDLE) && start;
  assign step_tap = (state == ST_RD_REQ) && mem_gnt && (tap != LAST_TAP);
  assign step_out = (state == ST_WR_REQ) && mem_gnt && !end_of_img;
  assign pix_data = pix_valid ? mem_rdata : '0;

  conv_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step_tap   (step_tap),
    .step_out   (step_out),
    .src_base   (src_base),
    .img_w      (img_w_q),
    .img_h      (img_h_q),
    .tap_addr   (tap_addr),
    .end_of_img (end_of_img)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      img_w_q   <= '0;
      img_h_q   <= '0;
      out_addr  <= '0;
      tap       <= '0;
      last_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pix_valid <= 1'b0;
      k_idx     <= '0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      pix_valid <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
    end else begin
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            img_w_q  <= img_w;
            img_h_q  <= img_h;
            out_addr <= dst_base;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (img_w_q < DIM_W'(KSIZE) || img_h_q < DIM_W'(KSIZE)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            tap      <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= tap_addr;
            state    <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            pix_valid <= 1'b1;
            k_idx     <= tap;
            pix_first <= (tap == '0);
            pix_last  <= (tap == LAST_TAP);
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (tap == LAST_TAP) begin
            state <= ST_WAIT_MAC;
          end else begin
            tap      <= tap + 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= tap_addr;
            state    <= ST_RD_REQ;
          end
        end
        ST_WAIT_MAC: begin
          if (mac_done) begin
            mem_wdata <= mac_result;
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
            mem_addr  <= out_addr;
            state     <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (mem_gnt) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            last_out <= end_of_img;
            state    <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (last_out) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            out_addr <= out_addr + 1'b1;
            tap      <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= tap_addr;
            state    <= ST_RD_REQ;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: RAM and MAC responders, expected transactions queued at each start.
module tb_conv_window_sequencer;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DIM_W-1:0]  img_w = '0;
  logic [DIM_W-1:0]  img_h = '0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic              mem_gnt = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mac_done = 1'b0;
  logic [DATA_W-1:0] mac_result = '0;
  logic              busy, done, err, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, pix_data;
  logic              pix_valid, pix_first, pix_last;
  logic [3:0]        k_idx;

  logic [DATA_W-1:0] mem [0:4095];
  txn_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                done_cnt = 0, req_cnt = 0, wr_cnt = 0, pix_cnt = 0, busy_cycles = 0;
  bit                rand_gnt = 1'b0;
  bit                mac_en = 1'b1;
  bit                pend = 1'b0;
  int                wait_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic              pend_we = 1'b0;
  int                k_exp = 0;
  int                acc = 0;
  bit                mac_fire = 1'b0;
  logic [DATA_W-1:0] last_rdata = '0;

  conv_window_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .img_w(img_w), .img_h(img_h), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .k_idx(k_idx),
    .pix_first(pix_first), .pix_last(pix_last),
    .mac_done(mac_done), .mac_result(mac_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pops the scoreboard for a transaction that is granted on the coming edge.
  task automatic recordTxn();
    txn_t e;
    if (mem_we) wr_cnt++;
    checkOutput("txn_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("txn_we", 32'(mem_we), 32'(e.we));
      checkOutput("txn_addr", 32'(mem_addr), 32'(e.addr));
      if (e.we) checkOutput("txn_wdata", 32'(mem_wdata), 32'(e.data));
    end
    if (!mem_we) begin
      mem_rdata  = mem[mem_addr];
      last_rdata = mem[mem_addr];
    end
  endtask

  // RAM responder: grants after 0..3 cycles in random mode and checks request stability.
  always @(negedge clk) begin
    if (mem_req) begin
      req_cnt++;
      if (!pend) begin
        pend      = 1'b1;
        pend_addr = mem_addr;
        pend_we   = mem_we;
        wait_cnt  = rand_gnt ? int'($urandom_range(3, 0)) : 0;
      end else begin
        checkOutput("addr_stable", 32'(mem_addr), 32'(pend_addr));
        checkOutput("we_stable", 32'(mem_we), 32'(pend_we));
      end
      if (wait_cnt == 0) begin
        mem_gnt = 1'b1;
        pend    = 1'b0;
        recordTxn();
      end else begin
        mem_gnt = 1'b0;
        wait_cnt--;
      end
    end else begin
      mem_gnt = 1'b0;
      pend    = 1'b0;
    end
  end

  // MAC model: weighted sum with weight (tap+1), result one cycle after the last tap.
  always @(negedge clk) begin
    if (mac_fire) begin
      mac_done   = 1'b1;
      mac_result = DATA_W'(acc);
      mac_fire   = 1'b0;
    end else begin
      mac_done = 1'b0;
    end
    if (done) begin
      done_cnt++;
      checkOutput("busy_with_done", 32'(busy), 32'd0);
    end
    if (busy) busy_cycles++;
    if (pix_valid) begin
      pix_cnt++;
      checkOutput("k_idx", 32'(k_idx), 32'(k_exp));
      checkOutput("pix_first", 32'(pix_first), 32'(k_exp == 0));
      checkOutput("pix_last", 32'(pix_last), 32'(k_exp == 8));
      checkOutput("pix_data", 32'(pix_data), 32'(last_rdata));
      acc = ((k_exp == 0) ? 0 : acc) + int'(pix_data) * (k_exp + 1);
      if (k_exp == 8 && mac_en) mac_fire = 1'b1;
      k_exp = (k_exp == 8) ? 0 : k_exp + 1;
    end
  end

  // Queues the full expected transaction trace, then pulses start.
  task automatic applyStimulus(input int w, input int h, input int src, input int dst);
    int n;
    n = 0;
    img_w    = DIM_W'(w);
    img_h    = DIM_W'(h);
    src_base = ADDR_W'(src);
    dst_base = ADDR_W'(dst);
    if (w >= 3 && h >= 3) begin
      for (int r = 0; r < h - 2; r++) begin
        for (int c = 0; c < w - 2; c++) begin
          int sum;
          sum = 0;
          for (int t = 0; t < 9; t++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(src + (r + t / 3) * w + c + t % 3);
            exp_q.push_back('{1'b0, a, 8'h00});
            sum += int'(mem[a]) * (t + 1);
          end
          exp_q.push_back('{1'b1, ADDR_W'(dst + n), DATA_W'(sum)});
          n++;
        end
      end
    end
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    src_base = ADDR_W'(12'h5A5);
    dst_base = ADDR_W'(12'hABC);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int d0, w0, p0, r0;
    for (int i = 0; i < 4096; i++) mem[i] = DATA_W'((i * 7 + 3) & 255);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
    rst_n = 1'b1;

    $display("[TB] 4x4 image, zero-wait grants");
    w0 = wr_cnt;
    applyStimulus(4, 4, 0, 256);
    waitDone("t1_done_once", 400);
    checkOutput("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("t1_writes", 32'(wr_cnt - w0), 32'd4);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_err", 32'(err), 32'd0);

    $display("[TB] 4x4 image, random grant delays");
    rand_gnt = 1'b1;
    w0 = wr_cnt;
    applyStimulus(4, 4, 0, 256);
    waitDone("t2_done_once", 800);
    checkOutput("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_writes", 32'(wr_cnt - w0), 32'd4);
    rand_gnt = 1'b0;

    $display("[TB] bad width with start and abort together");
    busy_cycles = 0;
    r0 = req_cnt;
    d0 = done_cnt;
    abort = 1'b1;
    applyStimulus(2, 4, 0, 256);
    abort = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("t3_busy_cycles", 32'(busy_cycles), 32'd1);
    checkOutput("t3_done", 32'(done_cnt - d0), 32'd1);
    checkOutput("t3_err", 32'(err), 32'd1);
    checkOutput("t3_no_req", 32'(req_cnt - r0), 32'd0);

    $display("[TB] reset during tap 5 of output 1");
    p0 = pix_cnt;
    d0 = done_cnt;
    applyStimulus(4, 4, 0, 256);
    for (int i = 0; i < 400 && (pix_cnt - p0) < 15; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("t4_reach_tap5", 32'(pix_cnt - p0), 32'd15);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_busy", 32'(busy), 32'd0);
    checkOutput("t4_rst_req", 32'(mem_req), 32'd0);
    checkOutput("t4_rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("t4_rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("t4_rst_err", 32'(err), 32'd0);
    exp_q.delete();
    k_exp    = 0;
    mac_fire = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    checkOutput("t4_no_done", 32'(done_cnt - d0), 32'd0);
    w0 = wr_cnt;
    rand_gnt = 1'b1;
    applyStimulus(4, 4, 0, 256);
    waitDone("t4_restart_done", 800);
    checkOutput("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("t4_writes", 32'(wr_cnt - w0), 32'd4);
    rand_gnt = 1'b0;

    $display("[TB] start while busy, abort in WAIT_MAC");
    mac_en = 1'b0;
    p0 = pix_cnt;
    d0 = done_cnt;
    w0 = wr_cnt;
    applyStimulus(4, 4, 0, 256);
    repeat (4) @(negedge clk);
    #1;
    img_w    = 8'd3;
    img_h    = 8'd3;
    dst_base = 12'd512;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400 && (pix_cnt - p0) < 9; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("t5_first_window", 32'(pix_cnt - p0), 32'd9);
    repeat (2) @(negedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("t5_abort_busy", 32'(busy), 32'd0);
    checkOutput("t5_abort_req", 32'(mem_req), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("t5_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("t5_no_write", 32'(wr_cnt - w0), 32'd0);
    checkOutput("t5_queue_left", 32'(exp_q.size()), 32'd31);
    exp_q.delete();
    mac_en = 1'b1;

    $display("[TB] 3x3 image with source address wrap");
    w0 = wr_cnt;
    applyStimulus(3, 3, 12'hFFE, 12'h200);
    waitDone("t6_done_once", 400);
    checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_writes", 32'(wr_cnt - w0), 32'd1);
    checkOutput("t6_err_clear", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
